// File: rtl/ttt_engine_nxn.sv
// ttt_engine_nxn: SIZE x SIZE, WIN_LEN-in-a-row two-player game engine.
// Takes cell selections, enforces legality and turn order, detects win or
// draw with a one-cell-per-cycle line walker, and drives a two-digit
// multiplexed 7-segment turn/result display.
module ttt_engine_nxn #(
  parameter  int SIZE    = 3,
  parameter  int WIN_LEN = 3,
  parameter  int SEG_DIV = 25000,
  localparam int CELLS   = SIZE * SIZE,
  localparam int CW      = $clog2(CELLS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             new_game,
  input  logic             key_valid,
  input  logic [CW-1:0]    key_data,
  output logic             key_ready,
  output logic             move_reject,
  output logic [CELLS-1:0] board_x,
  output logic [CELLS-1:0] board_o,
  output logic             turn_o,
  output logic [1:0]       result,
  output logic [6:0]       seg_txt,
  output logic [7:0]       seg_com
);

  localparam int              DIVW     = (SEG_DIV > 1) ? $clog2(SEG_DIV) : 1;
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(SEG_DIV - 1);
  localparam logic [CW:0]     CELLS_C  = (CW + 1)'(CELLS);
  localparam logic [3:0]      WL       = 4'(WIN_LEN);
  localparam logic [3:0]      WL1      = 4'(WIN_LEN - 1);
  localparam logic signed [4:0] SZ     = 5'(SIZE);

  localparam logic [6:0] SEG_P   = 7'b1110011;
  localparam logic [6:0] SEG_1   = 7'b0000110;
  localparam logic [6:0] SEG_2   = 7'b1011011;
  localparam logic [6:0] SEG_D   = 7'b1011110;
  localparam logic [6:0] SEG_R   = 7'b1010000;
  localparam logic [7:0] COM_D0  = 8'b01111111;
  localparam logic [7:0] COM_D1  = 8'b10111111;

  typedef enum logic [1:0] {IDLE, PLACE, WALK, DONE} state_t;

  state_t                  state_q;
  logic [CELLS-1:0]        board_x_q, board_o_q;
  logic                    turn_q, key_ready_q, reject_q;
  logic [1:0]              result_q;
  logic [CW-1:0]           key_q;
  logic [CW:0]             cnt_q;
  // walker: origin of the placed mark, cursor, direction, side, steps, run
  logic signed [4:0]       org_r_q, org_c_q, pos_r_q, pos_c_q;
  logic [1:0]              dir_q;
  logic                    side_q;
  logic [3:0]              steps_q, run_q;

  logic [DIVW-1:0]         div_q;
  logic                    dsel_q, dsel_d, div_wrap;
  logic [6:0]              seg_txt_q, seg_txt_d;
  logic [7:0]              seg_com_q, seg_com_d;

  logic signed [4:0]       dr, dc, cand_r, cand_c;
  logic                    in_bounds, cand_mark, key_bad;
  logic [7:0]              cand_lin;
  logic [CELLS-1:0]        mover_board, mark_shift, occ_shift;
  logic [3:0]              run_inc, step_inc;

  // Candidate cell for the walker and legality of the offered key.
  always_comb begin
    dr = 5'sd0;
    dc = 5'sd1;
    unique case (dir_q)
      2'd0: begin dr = 5'sd0; dc = 5'sd1;  end
      2'd1: begin dr = 5'sd1; dc = 5'sd0;  end
      2'd2: begin dr = 5'sd1; dc = 5'sd1;  end
      2'd3: begin dr = 5'sd1; dc = -5'sd1; end
    endcase
    if (side_q) begin
      dr = -dr;
      dc = -dc;
    end
    cand_r      = pos_r_q + dr;
    cand_c      = pos_c_q + dc;
    in_bounds   = (cand_r >= 5'sd0) && (cand_r < SZ) &&
                  (cand_c >= 5'sd0) && (cand_c < SZ);
    cand_lin    = 8'(cand_r[3:0]) * 8'(SIZE) + 8'(cand_c[3:0]);
    mover_board = turn_q ? board_o_q : board_x_q;
    mark_shift  = mover_board >> cand_lin;
    cand_mark   = in_bounds & mark_shift[0];
    run_inc     = run_q + 4'd1;
    step_inc    = steps_q + 4'd1;
    occ_shift   = (board_x_q | board_o_q) >> key_data;
    key_bad     = (int'(key_data) >= CELLS) | occ_shift[0];
  end

  // Game FSM: move acceptance, placement, line walk and resolution.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      board_x_q   <= '0;
      board_o_q   <= '0;
      turn_q      <= 1'b0;
      result_q    <= 2'b00;
      key_ready_q <= 1'b1;
      reject_q    <= 1'b0;
      cnt_q       <= '0;
      key_q       <= '0;
      org_r_q     <= '0;
      org_c_q     <= '0;
      pos_r_q     <= '0;
      pos_c_q     <= '0;
      dir_q       <= 2'd0;
      side_q      <= 1'b0;
      steps_q     <= 4'd0;
      run_q       <= 4'd1;
    end else if (new_game) begin
      // walker registers are reloaded in PLACE, so only game state clears
      state_q     <= IDLE;
      board_x_q   <= '0;
      board_o_q   <= '0;
      turn_q      <= 1'b0;
      result_q    <= 2'b00;
      key_ready_q <= 1'b1;
      reject_q    <= 1'b0;
      cnt_q       <= '0;
    end else begin
      reject_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (key_valid) begin
            if (key_bad) begin
              reject_q <= 1'b1;
            end else begin
              key_q       <= key_data;
              key_ready_q <= 1'b0;
              state_q     <= PLACE;
            end
          end
        end
        PLACE: begin
          if (turn_q) board_o_q <= board_o_q | (CELLS'(1) << key_q);
          else        board_x_q <= board_x_q | (CELLS'(1) << key_q);
          cnt_q   <= cnt_q + (CW + 1)'(1);
          org_r_q <= 5'(int'(key_q) / SIZE);
          org_c_q <= 5'(int'(key_q) % SIZE);
          pos_r_q <= 5'(int'(key_q) / SIZE);
          pos_c_q <= 5'(int'(key_q) % SIZE);
          dir_q   <= 2'd0;
          side_q  <= 1'b0;
          steps_q <= 4'd0;
          run_q   <= 4'd1;
          state_q <= WALK;
        end
        WALK: begin
          if (cand_mark) run_q <= run_inc;
          if (cand_mark && run_inc >= WL) begin
            result_q    <= turn_q ? 2'b10 : 2'b01;
            key_ready_q <= 1'b1;
            state_q     <= DONE;
          end else if (cand_mark && step_inc != WL1) begin
            pos_r_q <= cand_r;
            pos_c_q <= cand_c;
            steps_q <= step_inc;
          end else if (!side_q) begin
            // positive side exhausted: restart from the origin going back
            side_q  <= 1'b1;
            pos_r_q <= org_r_q;
            pos_c_q <= org_c_q;
            steps_q <= 4'd0;
          end else if (dir_q != 2'd3) begin
            dir_q   <= dir_q + 2'd1;
            side_q  <= 1'b0;
            pos_r_q <= org_r_q;
            pos_c_q <= org_c_q;
            steps_q <= 4'd0;
            run_q   <= 4'd1;
          end else if (cnt_q == CELLS_C) begin
            result_q    <= 2'b11;
            key_ready_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            turn_q      <= ~turn_q;
            key_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        DONE: begin
          if (key_valid) reject_q <= 1'b1;
        end
      endcase
    end
  end

  // Digit slot timing and glyph selection for the next display state.
  always_comb begin
    div_wrap  = (div_q == DIV_LAST);
    dsel_d    = div_wrap ? ~dsel_q : dsel_q;
    seg_com_d = dsel_d ? COM_D1 : COM_D0;
    seg_txt_d = SEG_P;
    if (!dsel_d) begin
      seg_txt_d = (result_q == 2'b11) ? SEG_D : SEG_P;
    end else begin
      unique case (result_q)
        2'b00: seg_txt_d = turn_q ? SEG_2 : SEG_1;
        2'b01: seg_txt_d = SEG_1;
        2'b10: seg_txt_d = SEG_2;
        2'b11: seg_txt_d = SEG_R;
      endcase
    end
  end

  // Display registers; new_game deliberately leaves the divider running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q     <= '0;
      dsel_q    <= 1'b0;
      seg_com_q <= COM_D0;
      seg_txt_q <= SEG_P;
    end else begin
      div_q     <= div_wrap ? '0 : div_q + DIVW'(1);
      dsel_q    <= dsel_d;
      seg_com_q <= seg_com_d;
      seg_txt_q <= seg_txt_d;
    end
  end

  assign key_ready   = key_ready_q;
  assign move_reject = reject_q;
  assign board_x     = board_x_q;
  assign board_o     = board_o_q;
  assign turn_o      = turn_q;
  assign result      = result_q;
  assign seg_txt     = seg_txt_q;
  assign seg_com     = seg_com_q;

endmodule

// File: tb/tb_ttt_engine_nxn.sv
// Testbench for ttt_engine_nxn: a 3x3 and a 5x5/4-in-a-row instance driven
// by directed games plus random games, checked against a board model.
module tb_ttt_engine_nxn;
  localparam int SD = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       ng3, kv3, kr3, rj3, t3;
  logic [3:0] kd3;
  logic [8:0] bx3, bo3;
  logic [1:0] r3;
  logic [6:0] st3;
  logic [7:0] sc3;

  logic        ng5, kv5, kr5, rj5, t5;
  logic [4:0]  kd5;
  logic [24:0] bx5, bo5;
  logic [1:0]  r5;
  logic [6:0]  st5;
  logic [7:0]  sc5;

  ttt_engine_nxn #(.SIZE(3), .WIN_LEN(3), .SEG_DIV(SD)) u3 (
    .clk(clk), .rst_n(rst_n), .new_game(ng3), .key_valid(kv3), .key_data(kd3),
    .key_ready(kr3), .move_reject(rj3), .board_x(bx3), .board_o(bo3),
    .turn_o(t3), .result(r3), .seg_txt(st3), .seg_com(sc3));

  ttt_engine_nxn #(.SIZE(5), .WIN_LEN(4), .SEG_DIV(SD)) u5 (
    .clk(clk), .rst_n(rst_n), .new_game(ng5), .key_valid(kv5), .key_data(kd5),
    .key_ready(kr5), .move_reject(rj5), .board_x(bx5), .board_o(bo5),
    .turn_o(t5), .result(r5), .seg_txt(st5), .seg_com(sc5));

  int compared   = 0;
  int mismatched = 0;

  // reference model: 0 empty, 1 X, 2 O
  int m_board [64];
  int m_turn, m_res, m_cnt;
  bit m_done;

  function automatic logic [63:0] o_bx(bit b);  return b ? 64'(bx5) : 64'(bx3); endfunction
  function automatic logic [63:0] o_bo(bit b);  return b ? 64'(bo5) : 64'(bo3); endfunction
  function automatic logic [63:0] o_rdy(bit b); return b ? 64'(kr5) : 64'(kr3); endfunction
  function automatic logic [63:0] o_rej(bit b); return b ? 64'(rj5) : 64'(rj3); endfunction
  function automatic logic [63:0] o_trn(bit b); return b ? 64'(t5)  : 64'(t3);  endfunction
  function automatic logic [63:0] o_res(bit b); return b ? 64'(r5)  : 64'(r3);  endfunction
  function automatic logic [7:0]  o_com(bit b); return b ? sc5 : sc3; endfunction
  function automatic logic [6:0]  o_txt(bit b); return b ? st5 : st3; endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) m_board[i] = 0;
    m_turn = 0; m_res = 0; m_cnt = 0; m_done = 1'b0;
  endtask

  function automatic logic [63:0] mask(int p);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 64; i++) if (m_board[i] == p) m[i] = 1'b1;
    return m;
  endfunction

  // brute-force scan of every WIN_LEN-long line on the board
  function automatic bit has_win(int n, int w, int p);
    int dr, dc, rr, cc;
    bit ok;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++)
        for (int d = 0; d < 4; d++) begin
          dr = (d == 0) ? 0 : 1;
          dc = (d == 1) ? 0 : ((d == 3) ? -1 : 1);
          ok = 1'b1;
          for (int t = 0; t < w; t++) begin
            rr = r + dr * t;
            cc = c + dc * t;
            if (rr < 0 || rr >= n || cc < 0 || cc >= n) ok = 1'b0;
            else if (m_board[rr * n + cc] != p) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic logic [6:0] exp_seg(int res, int turn, logic [7:0] com);
    if (com == 8'b01111111) return (res == 3) ? 7'b1011110 : 7'b1110011;
    if (res == 3) return 7'b1010000;
    if (res == 1) return 7'b0000110;
    if (res == 2) return 7'b1011011;
    return (turn == 1) ? 7'b1011011 : 7'b0000110;
  endfunction

  task automatic drive(input bit b, input bit v, input int k);
    if (b) begin kv5 = v; kd5 = 5'(k); end
    else   begin kv3 = v; kd3 = 4'(k); end
  endtask

  task automatic check_state(input bit b, input string tag);
    chk({tag, "_board_x"}, o_bx(b), mask(1));
    chk({tag, "_board_o"}, o_bo(b), mask(2));
    chk({tag, "_turn"}, o_trn(b), 64'(m_turn));
    chk({tag, "_result"}, o_res(b), 64'(m_res));
    chk({tag, "_key_ready"}, o_rdy(b), 64'd1);
  endtask

  task automatic check_reset(input bit b, input string tag);
    chk({tag, "_board_x"}, o_bx(b), 64'd0);
    chk({tag, "_board_o"}, o_bo(b), 64'd0);
    chk({tag, "_turn"}, o_trn(b), 64'd0);
    chk({tag, "_result"}, o_res(b), 64'd0);
    chk({tag, "_key_ready"}, o_rdy(b), 64'd1);
    chk({tag, "_reject"}, o_rej(b), 64'd0);
    chk({tag, "_seg_com"}, 64'(o_com(b)), 64'h7F);
    chk({tag, "_seg_txt"}, 64'(o_txt(b)), 64'h73);
  endtask

  task automatic new_game(input bit b);
    if (b) ng5 = 1'b1; else ng3 = 1'b1;
    @(negedge clk);
    ng5 = 1'b0; ng3 = 1'b0;
    model_clear();
    check_state(b, "new_game");
    chk("new_game_reject", o_rej(b), 64'd0);
  endtask

  task automatic check_disp(input bit b, input int n);
    bit seen0, seen1;
    logic [7:0] com;
    seen0 = 1'b0; seen1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      com = o_com(b);
      if (com == 8'b01111111) seen0 = 1'b1;
      if (com == 8'b10111111) seen1 = 1'b1;
      chk("seg_com_legal", 64'(com == 8'b01111111 || com == 8'b10111111), 64'd1);
      chk("seg_txt", 64'(o_txt(b)), 64'(exp_seg(m_res, m_turn, com)));
      @(negedge clk);
    end
    if (n >= 2 * SD) chk("seg_both_digits", 64'(seen0 && seen1), 64'd1);
  endtask

  task automatic play(input bit b, input int k, input bit inject);
    int cells, w, lim, cyc;
    bit exp_rej, inj;
    cells = b ? 25 : 9;
    w     = b ? 4 : 3;
    lim   = 2 + 8 * (w - 1);
    cyc   = 0;
    while (o_rdy(b) !== 64'd1 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("ready_before_move", o_rdy(b), 64'd1);
    exp_rej = m_done || (k >= cells) || (m_board[k] != 0);
    inj     = inject && !exp_rej;
    drive(b, 1'b1, k);
    @(negedge clk);
    cyc = 1;
    chk("move_reject", o_rej(b), 64'(exp_rej));
    if (inj) begin
      drive(b, 1'b1, (k + 1) % cells);
      @(negedge clk);
      cyc = 2;
      chk("busy_key_ignored", o_rej(b), 64'd0);
    end
    drive(b, 1'b0, 0);
    if (exp_rej) begin
      check_state(b, "after_reject");
    end else begin
      m_board[k] = m_turn + 1;
      m_cnt++;
      if (has_win(b ? 5 : 3, w, m_turn + 1)) begin
        m_res = m_turn + 1; m_done = 1'b1;
      end else if (m_cnt == cells) begin
        m_res = 3; m_done = 1'b1;
      end else begin
        m_turn = 1 - m_turn;
      end
      while (o_rdy(b) !== 64'd1 && cyc < lim + 20) begin @(negedge clk); cyc++; end
      chk("latency_in_bound", 64'(cyc <= lim), 64'd1);
      check_state(b, "after_move");
    end
    $display("move dut=%0d key=%0d reject=%0d inject=%0d cycles=%0d result=%0d turn=%0d",
             b ? 5 : 3, k, exp_rej, inj, cyc, m_res, m_turn);
  endtask

  task automatic random_game(input bit b);
    int cells, kmax, n, k;
    cells = b ? 25 : 9;
    kmax  = b ? 31 : 15;
    new_game(b);
    n = 0;
    while (!m_done && n < 200) begin
      if ($urandom_range(0, 3) == 0) begin
        k = $urandom_range(0, kmax);
      end else begin
        k = $urandom_range(0, cells - 1);
        for (int i = 0; i < cells; i++)
          if (m_board[(k + i) % cells] == 0) begin k = (k + i) % cells; break; end
      end
      play(b, k, $urandom_range(0, 7) == 0);
      n++;
    end
    play(b, $urandom_range(0, kmax), 1'b0);
    check_disp(b, 6);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int row_moves[5]  = '{0, 3, 1, 4, 2};
    int draw_moves[9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};
    int diag_moves[7] = '{0, 1, 6, 2, 12, 3, 18};

    rst_n = 1'b0;
    ng3 = 1'b0; kv3 = 1'b0; kd3 = '0;
    ng5 = 1'b0; kv5 = 1'b0; kd5 = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check_reset(0, "por3");
    check_reset(1, "por5");
    rst_n = 1'b1;
    @(negedge clk);
    check_disp(0, 2 * SD + 2);

    // row win for X, then a key in DONE is refused
    new_game(0);
    foreach (row_moves[i]) play(0, row_moves[i], 1'b0);
    chk("row_win_result", o_res(0), 64'd1);
    chk("row_win_board_x", o_bx(0), 64'h007);
    chk("row_win_board_o", o_bo(0), 64'h018);
    chk("row_win_turn", o_trn(0), 64'd0);
    play(0, 5, 1'b0);
    check_disp(0, 2 * SD + 2);

    // occupied cell, out-of-range cell, key while busy
    new_game(0);
    play(0, 4, 1'b0);
    play(0, 4, 1'b0);
    chk("occupied_turn_hold", o_trn(0), 64'd1);
    play(0, 9, 1'b0);
    play(0, 0, 1'b1);

    // full-board draw
    new_game(0);
    foreach (draw_moves[i]) play(0, draw_moves[i], 1'b0);
    chk("draw_result", o_res(0), 64'd3);
    check_disp(0, 2 * SD + 2);

    // new_game inside WALK aborts the move
    new_game(0);
    play(0, 0, 1'b0);
    drive(0, 1'b1, 4);
    @(negedge clk);
    drive(0, 1'b0, 0);
    @(negedge clk);
    ng3 = 1'b1;
    @(negedge clk);
    ng3 = 1'b0;
    model_clear();
    check_state(0, "abort");

    // new_game wins over a simultaneous key
    ng3 = 1'b1;
    drive(0, 1'b1, 2);
    @(negedge clk);
    ng3 = 1'b0;
    drive(0, 1'b0, 0);
    chk("ng_vs_key_reject", o_rej(0), 64'd0);
    repeat (3) @(negedge clk);
    check_state(0, "ng_vs_key");

    // asynchronous reset while walking
    play(0, 4, 1'b0);
    drive(0, 1'b1, 0);
    @(negedge clk);
    drive(0, 1'b0, 0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset(0, "async_rst3");
    check_reset(1, "async_rst5");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    check_state(0, "after_async_rst");
    check_disp(0, 2 * SD + 2);

    // 5x5, 4-in-a-row: diagonal win (0,6,12 alone is not enough)
    new_game(1);
    foreach (diag_moves[i]) begin
      play(1, diag_moves[i], 1'b0);
      if (i == 4) chk("three_run_no_win", o_res(1), 64'd0);
    end
    chk("diag_win_result", o_res(1), 64'd1);
    check_disp(1, 2 * SD + 2);

    // random games on both sizes
    for (int g = 0; g < 8; g++) random_game(g[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
